pipe_alu: RTL and testbench
===========================

PIPE_ALU -- requirements
Module: pipe_alu

Interface
REQ-001 WIDTH, 4, operand/result width in bits; SHALL be a power of two, >= 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  operand/op presented.
REQ-005 in_ready  output  1  block can accept; transfer when in_valid && in_ready at a clk edge.
REQ-006 a, b  input  WIDTH each  operands.
REQ-007 sel  input  3  op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-008 out_valid  output  1  result registers hold an unconsumed result.
REQ-009 out_ready  input  1  consumer accepts; result transfers when out_valid && out_ready.
REQ-010 y  output  WIDTH  result.
REQ-011 c  output  1  carry/borrow/shift-out/overflow flag.
REQ-012 z  output  1  1 iff y == 0.

Function
REQ-013 States SHALL be IDLE and MUL_BUSY only.
REQ-014 in_ready SHALL equal (state == IDLE) && (!out_valid || out_ready), combinationally.
REQ-015 Non-MUL op accepted at edge k: y/c/z SHALL load and out_valid SHALL be 1 after edge k (latency 1); state stays IDLE.
REQ-016 MUL accepted at edge k: state -> MUL_BUSY; one shift-add iteration per cycle; result loads with out_valid = 1 at edge k+WIDTH; state -> IDLE at same edge.
REQ-017 In MUL_BUSY, in_ready SHALL be 0 and a, b, sel SHALL be ignored.
REQ-018 out_valid SHALL clear at an edge where out_valid && out_ready and no new result loads; simultaneous consume and load SHALL leave out_valid = 1 with the new result (no bubble).
REQ-019 With out_valid && !out_ready, y, c, z SHALL hold stable.
REQ-020 ADD: y = (a+b) mod 2^WIDTH, c = carry-out.
REQ-021 SUB: y = (a-b) mod 2^WIDTH, c = 1 iff a < b (borrow).
REQ-022 AND/OR/XOR: bitwise, c = 0.
REQ-023 SHL/SHR: shift amount s = b mod WIDTH, zero-fill; c = last bit shifted out, 0 when s = 0.
REQ-024 MUL: y = low WIDTH bits of a*b (unsigned), c = 1 iff high WIDTH bits nonzero.
REQ-025 z SHALL be computed from the loaded y for every op.

Reset
REQ-026 rst_n low SHALL immediately force state = IDLE, out_valid = 0, y = 0, c = 0, z = 0, iteration counter = 0.
REQ-027 Reset during MUL_BUSY SHALL abort the multiply; no result SHALL appear after reset release.
REQ-028 in_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-029 A shared package alu_pkg SHALL hold the op enum alu_op_e (encodings per REQ-007) and state enum alu_state_e.
REQ-030 The iterative multiplier SHALL be a sub-module alu_mul_seq (start, a, b -> done, product[2*WIDTH-1:0]), with the iteration counter sized $clog2(WIDTH)+1.
REQ-031 All other ops SHALL be combinational logic feeding the result registers in pipe_alu.

Verification (WIDTH = 4)
REQ-032 ADD a=9 b=8, out_ready=1 -> next cycle y=1, c=1, z=0, out_valid=1.
REQ-033 SUB a=3 b=5 -> y=14, c=1; SUB a=5 b=5 -> y=0, c=0, z=1.
REQ-034 SHL a=4'b1011 b=6 (s=2) -> y=4'b1100, c=0; SHR a=4'b1011 b=1 -> y=4'b0101, c=1.
REQ-035 MUL a=7 b=3 -> in_ready=0 for 4 cycles, out_valid exactly 4 edges after accept, y=5, c=1; MUL a=3 b=5 -> y=15, c=0.
REQ-036 Back-to-back ADDs with out_ready held 0 for 3 cycles -> in_ready=0 while full, y stable, no result lost or duplicated after release.
REQ-037 rst_n pulsed low 2 cycles into a MUL -> outputs zero immediately, no out_valid afterward, next ADD a=1 b=1 -> y=2.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types for the pipelined ALU slice:
//   alu_op_e     - operation select encoding driven on the sel port
//   alu_state_e  - control states of pipe_alu (idle / multiply in progress)
//   ALU_DEFAULT_WIDTH - default operand/result width
//   isMulOp()    - true for the only multi-cycle operation
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_DEFAULT_WIDTH = 4;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } alu_state_e;

    // Multiply is the only operation that goes through the iterative unit.
    function automatic logic isMulOp(input alu_op_e op);
        return (op == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq
// Unsigned shift-add multiplier, one partial product per clock.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   start          - load a/b and begin a multiply (ignored semantics while
//                    busy are the caller's responsibility)
//   a, b           - WIDTH-bit unsigned operands
//   done           - product is complete this cycle (one-cycle pulse)
//   product        - full 2*WIDTH-bit product, valid while done is high
// Timing: start sampled at edge k, done is high in the cycle ending at edge
// k+WIDTH, so the caller can register the product on that edge.
// ---------------------------------------------------------------------------
module alu_mul_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      count_q;
    logic               busy_q;

    // The first partial product (multiplier bit 0) is folded into the load
    // edge, so only WIDTH-1 further iterations are needed. That lets the
    // finished product sit in acc_q during the cycle before edge k+WIDTH,
    // where the top level registers it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            acc_q    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand_q  <= {{WIDTH{1'b0}}, a} << 1;
            mplier_q <= b >> 1;
            count_q  <= CW'(WIDTH - 1);
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            if (count_q != '0) begin
                acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                count_q  <= count_q - CW'(1);
            end else begin
                busy_q   <= 1'b0;
            end
        end
    end

    assign done    = busy_q && (count_q == '0);
    assign product = acc_q;

endmodule

// File: rtl/pipe_alu.sv
// ---------------------------------------------------------------------------
// pipe_alu
// Single-entry pipelined ALU with valid/ready handshakes on both sides.
// Single-cycle ops load the result registers on the accept edge; MUL runs
// through alu_mul_seq and loads WIDTH edges after accept.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - input handshake (a, b, sel transfer when both high)
//   a, b                 - WIDTH-bit operands
//   sel                  - operation, encoded as alu_pkg::alu_op_e
//   out_valid / out_ready- output handshake (y, c, z transfer when both high)
//   y                    - result
//   c                    - carry / borrow / shift-out / multiply overflow
//   z                    - result is zero
// ---------------------------------------------------------------------------
module pipe_alu #(
    parameter int WIDTH = alu_pkg::ALU_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             c,
    output logic             z
);

    import alu_pkg::*;

    localparam int SW = $clog2(WIDTH);

    alu_state_e          state_q;
    logic                outValid_q;
    logic [WIDTH-1:0]    y_q;
    logic                c_q;
    logic                z_q;

    alu_op_e             op;
    logic                accept;
    logic                mulStart;
    logic                mulDone;
    logic [2*WIDTH-1:0]  mulProduct;
    logic                loadResult;

    logic [WIDTH:0]      sumExt;
    logic [WIDTH:0]      shlExt;
    logic [WIDTH:0]      shrExt;
    logic [SW-1:0]       shAmt;
    logic [WIDTH-1:0]    aluY;
    logic                aluC;

    logic [WIDTH-1:0]    y_d;
    logic                c_d;
    logic                z_d;
    logic                outValid_d;

    assign op = alu_op_e'(sel);

    // The result register can take a new value when it is empty or being
    // drained this edge; a multiply in flight blocks new work entirely.
    assign in_ready   = (state_q == ST_IDLE) && (!outValid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign mulStart   = accept && isMulOp(op);
    assign loadResult = (accept && !isMulOp(op)) || ((state_q == ST_MUL_BUSY) && mulDone);

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mulStart),
        .a       (a),
        .b       (b),
        .done    (mulDone),
        .product (mulProduct)
    );

    // Single-cycle datapath. Shifts are done one bit wider than the operand
    // so the last bit shifted out lands in a fixed position (the extra MSB
    // for left, the extra LSB for right); a zero shift leaves that bit 0.
    always_comb begin
        sumExt = {1'b0, a} + {1'b0, b};
        shAmt  = b[SW-1:0];
        shlExt = {1'b0, a} << shAmt;
        shrExt = {a, 1'b0} >> shAmt;
        aluY   = '0;
        aluC   = 1'b0;
        case (op)
            OP_ADD: begin
                aluY = sumExt[WIDTH-1:0];
                aluC = sumExt[WIDTH];
            end
            OP_SUB: begin
                aluY = a - b;
                aluC = (a < b);
            end
            OP_AND: aluY = a & b;
            OP_OR:  aluY = a | b;
            OP_XOR: aluY = a ^ b;
            OP_SHL: begin
                aluY = shlExt[WIDTH-1:0];
                aluC = shlExt[WIDTH];
            end
            OP_SHR: begin
                aluY = shrExt[WIDTH:1];
                aluC = shrExt[0];
            end
            default: begin
                aluY = '0;
                aluC = 1'b0;
            end
        endcase
    end

    // Select what the result registers load: the multiplier product while a
    // multiply is finishing, otherwise the single-cycle datapath.
    always_comb begin
        if (state_q == ST_MUL_BUSY) begin
            y_d = mulProduct[WIDTH-1:0];
            c_d = |mulProduct[2*WIDTH-1:WIDTH];
        end else begin
            y_d = aluY;
            c_d = aluC;
        end
        z_d = (y_d == '0);

        if (loadResult) begin
            outValid_d = 1'b1;
        end else if (out_ready) begin
            outValid_d = 1'b0;
        end else begin
            outValid_d = outValid_q;
        end
    end

    // Control FSM and result registers. y/c/z only change on a load, so
    // they hold steady while the consumer stalls and keep the last value
    // after it has been consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            outValid_q <= 1'b0;
            y_q        <= '0;
            c_q        <= 1'b0;
            z_q        <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:     if (mulStart) state_q <= ST_MUL_BUSY;
                ST_MUL_BUSY: if (mulDone)  state_q <= ST_IDLE;
                default:                   state_q <= ST_IDLE;
            endcase
            outValid_q <= outValid_d;
            if (loadResult) begin
                y_q <= y_d;
                c_q <= c_d;
                z_q <= z_d;
            end
        end
    end

    assign out_valid = outValid_q;
    assign y         = y_q;
    assign c         = c_q;
    assign z         = z_q;

endmodule

// File: tb/tb_pipe_alu.sv
// ---------------------------------------------------------------------------
// tb_pipe_alu
// Self-checking bench for pipe_alu (WIDTH = 4). A reference model computes
// each accepted operation arithmetically and keeps a queue of pending
// results with the cycle at which each should become visible; every cycle
// the DUT handshake signals and outputs are compared against that queue.
// ---------------------------------------------------------------------------
module tb_pipe_alu;

    localparam int W = 4;
    localparam int M = 1 << W;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   sel = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] y;
    logic         c;
    logic         z;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int y;
        int c;
        int z;
        int readyCyc;
    } exp_t;

    exp_t expQ[$];

    pipe_alu #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .c         (c),
        .z         (z)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Single point of comparison: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Arithmetic reference for one operation, independent of any datapath.
    function automatic exp_t refModel(input int op, input int av, input int bv);
        exp_t e;
        int   s;
        int   r;
        e.y = 0;
        e.c = 0;
        e.readyCyc = 0;
        s = bv % W;
        case (op)
            0: begin r = av + bv;       e.y = r % M; e.c = (r >= M) ? 1 : 0; end
            1: begin r = av - bv;       e.y = (r + M) % M; e.c = (av < bv) ? 1 : 0; end
            2: e.y = av & bv;
            3: e.y = av | bv;
            4: e.y = av ^ bv;
            5: begin
                r   = av << s;
                e.y = r % M;
                e.c = (s == 0) ? 0 : ((av >> (W - s)) & 1);
            end
            6: begin
                e.y = av >> s;
                e.c = (s == 0) ? 0 : ((av >> (s - 1)) & 1);
            end
            default: begin
                r   = av * bv;
                e.y = r % M;
                e.c = ((r / M) != 0) ? 1 : 0;
            end
        endcase
        e.z = (e.y == 0) ? 1 : 0;
        return e;
    endfunction

    // Drive one cycle of inputs (called just after a falling edge), check the
    // DUT against the model, then advance through the next rising edge and
    // update the model with whatever transferred on it.
    task automatic applyStimulus(input logic inV, input logic [2:0] op,
                                 input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic outR);
        logic headVis;
        logic expReady;
        logic accepted;
        logic consumed;
        exp_t e;
        in_valid  = inV;
        sel       = op;
        a         = av;
        b         = bv;
        out_ready = outR;
        #1;
        headVis  = (expQ.size() > 0) && (cyc >= expQ[0].readyCyc);
        expReady = (expQ.size() == 0) || (headVis && outR);
        checkOutput("out_valid", out_valid, headVis);
        checkOutput("in_ready", in_ready, expReady);
        if (headVis) begin
            checkOutput("y", y, expQ[0].y);
            checkOutput("c", c, expQ[0].c);
            checkOutput("z", z, expQ[0].z);
        end
        accepted = inV && expReady;
        consumed = headVis && outR;
        e = refModel(int'(op), int'(av), int'(bv));
        @(posedge clk);
        cyc++;
        if (consumed) void'(expQ.pop_front());
        if (accepted) begin
            e.readyCyc = (op == OP_MUL) ? cyc + W : cyc;
            expQ.push_back(e);
        end
        @(negedge clk);
    endtask

    // One directed operation with fixed expected result values, then drained.
    task automatic runDirected(input string tag, input logic [2:0] op,
                               input logic [W-1:0] av, input logic [W-1:0] bv,
                               input int yE, input int cE, input int zE);
        applyStimulus(1'b1, op, av, bv, 1'b1);
        if (op == OP_MUL) begin
            for (int i = 0; i < W; i++) applyStimulus(1'b0, OP_ADD, '0, '0, 1'b0);
        end
        #1;
        checkOutput({tag, ".valid"}, out_valid, 1);
        checkOutput({tag, ".y"}, y, yE);
        checkOutput({tag, ".c"}, c, cE);
        checkOutput({tag, ".z"}, z, zE);
        @(negedge clk);
        applyStimulus(1'b0, OP_ADD, '0, '0, 1'b1);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        #1;
        checkOutput("rst.out_valid", out_valid, 0);
        checkOutput("rst.y", y, 0);
        checkOutput("rst.c", c, 0);
        checkOutput("rst.z", z, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed operations
        runDirected("add_9_8",  OP_ADD, 4'd9,      4'd8, 1,       1, 0);
        runDirected("sub_3_5",  OP_SUB, 4'd3,      4'd5, 14,      1, 0);
        runDirected("sub_5_5",  OP_SUB, 4'd5,      4'd5, 0,       0, 1);
        runDirected("shl_s2",   OP_SHL, 4'b1011,   4'd6, 4'b1100, 0, 0);
        runDirected("shr_s1",   OP_SHR, 4'b1011,   4'd1, 4'b0101, 1, 0);
        runDirected("shl_s0",   OP_SHL, 4'b1011,   4'd4, 4'b1011, 0, 0);
        runDirected("xor",      OP_XOR, 4'b1100,   4'b1010, 4'b0110, 0, 0);
        runDirected("mul_7_3",  OP_MUL, 4'd7,      4'd3, 5,       1, 0);
        runDirected("mul_3_5",  OP_MUL, 4'd3,      4'd5, 15,      0, 0);

        // Back-to-back ADDs with the consumer stalled for three cycles
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, OP_ADD, W'(i + 1), 4'd2, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, OP_ADD, W'(i + 5), 4'd1, 1'b1);
        applyStimulus(1'b0, OP_ADD, '0, '0, 1'b1);
        checkOutput("bp.drained", expQ.size(), 0);

        // Reset two cycles into a multiply
        applyStimulus(1'b1, OP_MUL, 4'd7, 4'd3, 1'b1);
        applyStimulus(1'b0, OP_ADD, '0, '0, 1'b1);
        applyStimulus(1'b0, OP_ADD, '0, '0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort.out_valid", out_valid, 0);
        checkOutput("abort.y", y, 0);
        checkOutput("abort.c", c, 0);
        checkOutput("abort.z", z, 0);
        expQ.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) applyStimulus(1'b0, OP_ADD, '0, '0, 1'b1);
        runDirected("add_1_1", OP_ADD, 4'd1, 4'd1, 2, 0, 0);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                          W'($urandom), W'($urandom), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < W + 2; i++) applyStimulus(1'b0, OP_ADD, '0, '0, 1'b1);
        checkOutput("final.drained", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
